ncc_corr_engine: RTL
====================

Name: ncc_corr_engine

Overview:
- Parametrised descriptor-by-window correlation engine: the successor to the fixed 16x16 NCC PE grid.
- Loads a ROWS x COLS signed descriptor through a packed-word valid/ready stream and holds it resident.
- Correlates any number of same-sized windows against it, each streamed in raster order.
- Emits one exact signed dot-product score per window, over a valid/ready output. Sits between the descriptor fetch path and the match/peak-selection stage in vision/.

Parameters:
- ROWS, 16, descriptor/window rows.
- COLS, 16, descriptor/window columns.
- PIX_W, 8, bits per pixel; signed two's complement.
- LANES, 4, pixels per stream word; ROWS*COLS must be divisible by LANES.
- ACC_W, 2*PIX_W+$clog2(ROWS*COLS)+1, accumulator and score width, signed.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- desc_valid  in  1  descriptor word valid
- desc_ready  out  1  engine accepts a descriptor word
- desc_data  in  LANES*PIX_W  descriptor pixels; lane 0 in the MSB slice, earliest in raster order
- desc_loaded  out  1  full descriptor resident
- desc_clear  in  1  discard descriptor, abort any in-progress window
- win_valid  in  1  window word valid
- win_ready  out  1  engine accepts a window word
- win_data  in  LANES*PIX_W  window pixels, same packing as desc_data
- score_valid  out  1  score available
- score_ready  in  1  downstream takes score
- score  out  ACC_W  signed correlation result

Behaviour:
- Reset rst, asynchronous, active-high; clock clk. Reset/abort state: EMPTY.
  - Outputs at reset: desc_loaded=0, score_valid=0, score=0, win_ready=0, desc_ready=1.
  - Counters, accumulator and descriptor storage all reset to 0.
- WORDS = ROWS*COLS/LANES. word_cnt counts 0..WORDS-1 and is shared by the load and correlate phases.
- Transfer rule: a transfer occurs on a rising clk edge with valid&ready both high. The valid side must hold its data stable until the transfer.
- State EMPTY/LOADING:
  - desc_ready = !desc_clear; win_ready=0.
  - Each descriptor transfer writes lanes into pixel indices word_cnt*LANES+lane, then increments word_cnt.
  - The first transfer moves to LOADING.
  - The transfer at word_cnt=WORDS-1 wraps word_cnt to 0 and moves to ARMED.
- State ARMED:
  - desc_loaded=1, desc_ready=0, win_ready = !desc_clear.
  - Each window transfer does acc += sum over lanes of desc[word_cnt*LANES+lane]*win_lane. Products are full 2*PIX_W signed and sign-extended to ACC_W.
  - The transfer at word_cnt=WORDS-1 loads score with the final sum, including that beat, then clears acc and word_cnt and moves to OUTPUT.
  - score_valid rises the cycle after the last window transfer.
- State OUTPUT:
  - score_valid=1; score held stable; win_ready=0, desc_ready=0; desc_clear is ignored.
  - On score_valid&score_ready, score_valid drops next cycle and the engine returns to ARMED. The descriptor is retained, so back-to-back windows need no reload.
  - Throughput: one window per WORDS+1 cycles with no backpressure.
- desc_clear in EMPTY, LOADING or ARMED (not OUTPUT):
  - Next state is EMPTY; word_cnt and acc are cleared; desc_loaded drops next cycle; no score is produced.
  - Ready is gated low by desc_clear in the same cycle, so a coincident beat is never accepted.
  - Stale descriptor pixels need not be zeroed; they are fully overwritten by the next load.
- Arithmetic: the default ACC_W cannot overflow. If ACC_W is overridden narrower, acc wraps modulo 2^ACC_W with no saturation.
- Async reset mid-load or mid-window aborts immediately to the reset values above.
- Elaboration error if ROWS*COLS % LANES != 0 or LANES < 1.

Test Plan:
- Lane order:
  - Load desc word0=0x01020304, remaining 63 words 0.
  - Window word0=0x0A000000, rest 0 -> score=10.
  - Next window word0=0x0000000A -> score=40. The descriptor is not reloaded between the two windows.
- Magnitude: desc all 0x01010101, window all 0x02020202 -> score=512. score_valid rises exactly 1 cycle after the 64th window transfer.
- Signed extremes:
  - desc all 0x80808080 (-128), window all 0x80808080 -> score=4194304.
  - Same desc, window all 0x7F7F7F7F -> score=-4161536.
- Backpressure and random valids:
  - Hold score_ready=0 for 10 cycles -> score stable, score_valid=1, win_ready=0 throughout.
  - Random gaps on win_valid/desc_valid -> same scores as gap-free runs.
- desc_clear abort:
  - Assert desc_clear after 30 window beats, coincident with win_valid=1 -> beat not accepted, no score_valid.
  - Then desc_loaded=0 and desc_ready=1.
  - Reload and run -> correct score.
- Async reset asserted mid-descriptor-load (word 20) and mid-window -> all outputs at reset values within the same cycle. The next full load+window produces a correct score.

Source files
------------

// File: rtl/ncc_corr_engine.sv
// Descriptor-by-window correlation engine: holds a ROWS x COLS signed descriptor
// resident and emits one exact signed dot-product score per streamed window.
module ncc_corr_engine #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 2*PIX_W + $clog2(ROWS*COLS) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    desc_valid,
  output logic                    desc_ready,
  input  logic [LANES*PIX_W-1:0]  desc_data,
  output logic                    desc_loaded,
  input  logic                    desc_clear,
  input  logic                    win_valid,
  output logic                    win_ready,
  input  logic [LANES*PIX_W-1:0]  win_data,
  output logic                    score_valid,
  input  logic                    score_ready,
  output logic signed [ACC_W-1:0] score
);

  localparam int WORDS  = (LANES < 1) ? 1 : (ROWS*COLS) / LANES;
  localparam int WORD_W = LANES*PIX_W;
  localparam int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  if (LANES < 1) begin : g_lanes_chk
    $error("ncc_corr_engine: LANES must be at least 1");
  end else if (((ROWS*COLS) % LANES) != 0) begin : g_div_chk
    $error("ncc_corr_engine: ROWS*COLS must be divisible by LANES");
  end

  typedef enum logic [1:0] {S_EMPTY, S_LOADING, S_ARMED, S_OUTPUT} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  score_q, score_d;
  logic [WORD_W-1:0]        desc_mem_q [WORDS];

  logic                     desc_xfer, win_xfer, last, abort;
  logic [WORD_W-1:0]        desc_word;
  logic signed [PIX_W-1:0]  dpix, wpix;
  logic signed [2*PIX_W-1:0] prod;
  logic signed [ACC_W-1:0]  beat_sum;

  assign desc_xfer = desc_valid & desc_ready;
  assign win_xfer  = win_valid & win_ready;
  assign last      = (cnt_q == CNT_W'(WORDS-1));
  assign abort     = desc_clear & (state_q != S_OUTPUT);
  assign desc_word = desc_mem_q[cnt_q];
  assign score     = score_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY, S_LOADING: begin
        if (abort)          state_d = S_EMPTY;
        else if (desc_xfer) state_d = last ? S_ARMED : S_LOADING;
      end
      S_ARMED: begin
        if (abort)                 state_d = S_EMPTY;
        else if (win_xfer && last) state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (score_ready) state_d = S_ARMED;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Output logic; ready is gated by desc_clear so a coincident beat is never taken
  always_comb begin
    desc_ready  = 1'b0;
    win_ready   = 1'b0;
    desc_loaded = 1'b0;
    score_valid = 1'b0;
    unique case (state_q)
      S_EMPTY, S_LOADING: desc_ready = ~desc_clear;
      S_ARMED: begin
        desc_loaded = 1'b1;
        win_ready   = ~desc_clear;
      end
      S_OUTPUT: begin
        desc_loaded = 1'b1;
        score_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Per-beat partial dot product: full-width signed lane products, sign-extended
  always_comb begin
    beat_sum = '0;
    dpix     = '0;
    wpix     = '0;
    prod     = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      dpix     = desc_word[(LANES-l)*PIX_W-1 -: PIX_W];
      wpix     = win_data[(LANES-l)*PIX_W-1 -: PIX_W];
      prod     = (2*PIX_W)'(dpix) * (2*PIX_W)'(wpix);
      beat_sum = beat_sum + ACC_W'(prod);
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    score_d = score_q;
    if (abort) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (desc_xfer) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end else if (win_xfer) begin
      if (last) begin
        cnt_d   = '0;
        acc_d   = '0;
        score_d = acc_q + beat_sum;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = acc_q + beat_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      score_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      score_q <= score_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < WORDS; i++) desc_mem_q[i] <= '0;
    end else if (desc_xfer) begin
      desc_mem_q[cnt_q] <= desc_data;
    end
  end

endmodule
